aes_inv_cipher_ctrl: RTL
========================

Name: aes_inv_cipher_ctrl

Overview:
- Sequencer for the AES-128 inverse-cipher datapath: state register plus InvShiftRows / InvSubBytes / InvAddRoundKey / InvMixColumns units.
- Steps one operation per cycle, selects the round key from the expanded key schedule, and drives the state-register load enable.
- InvMixColumns is time-multiplexed over the four 32-bit columns.
- Sits between the top-level AES wrapper (start/done handshake) and the datapath.

Parameters:
- NR, 10, number of rounds. AES-128 only; other values unsupported.
- KEY_W, 128, state and round-key width in bits.

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous reset, active-high.
- start  in  1  begin decryption; level handshake.
- key_schedule  in  (NR+1)*KEY_W  expanded keys. Round r key is bits [KEY_W*r +: KEY_W]; r=0 is the cipher key.
- key_ready  in  1  present only with AES_CTRL_KEYWAIT_EN.
- op_sel  out  3  datapath mux select: 0 NONE, 1 LOAD, 2 ISR, 3 ISB, 4 ARK, 5 IMC.
- state_ld  out  1  state register write enable.
- imc_word  out  2  column written by IMC, 0 = bits [127:96].
- round  out  4  current round index.
- round_key  out  KEY_W  combinational slice of key_schedule at index round.
- busy  out  1  high from LOAD through final ARK.
- done  out  1  result valid in state register.

Behaviour:
- Reset values: FSM IDLE, round=NR, op_sel=0, state_ld=0, imc_word=0, busy=0, done=0. RESET wins over every other input; asserted mid-operation it returns to IDLE next edge and drops busy/done.
- All control outputs are registered except round_key.
- FSM states: IDLE, LOAD, ARK0, ISR, ISB, ARK, IMC, DONE.
- IDLE: waits for start=1, then goes to LOAD.
- LOAD: op_sel=1, state_ld=1; captures the ciphertext. Next ARK0.
- ARK0: op_sel=4, round=NR. Then round<=NR-1 and go to ISR.
- ISR: op_sel=2. Next ISB.
- ISB: op_sel=3. Next ARK.
- ARK: op_sel=4. If round==0, go to DONE; else go to IMC with imc_word=0.
- IMC: op_sel=5. imc_word counts 0..3, one column per cycle. After imc_word==3: round<=round-1, imc_word<=0, go to ISR.
- DONE: done=1, busy=0, state_ld=0. Held while start=1; start=0 returns to IDLE with done<=0 on that edge.
- state_ld=1 in every state except IDLE and DONE.
- Latency:
  - 1 LOAD + 1 ARK0 + 9×(ISR+ISB+ARK+4 IMC = 7) + final ISR/ISB/ARK (3) = 68 busy cycles.
  - done goes high on the 69th edge after the edge that sampled start in IDLE.
- start is ignored while busy. Keeping start high after DONE does not retrigger; a new run needs start low for at least one cycle.
- key_schedule must stay stable from LOAD until done.
- round is 4-bit with no wrap. The decrement happens only in IMC, so round never underflows below 0.

Optional Feature:
- Macro: AES_CTRL_KEYWAIT_EN.
- Defined: adds input key_ready and state KWAIT between IDLE and LOAD. In KWAIT, busy=1, state_ld=0, op_sel=0; the FSM leaves KWAIT on key_ready=1. If key_ready is already 1 when start is sampled, KWAIT lasts exactly one cycle.
- Undefined: no key_ready port, no KWAIT; key_schedule is assumed valid at start.

Decomposition:
- Package aes_ctrl_pkg: op_e enum (NONE..IMC), ctrl_state_e enum, NR_DEF=10, KEY_W_DEF=128.
- One sub-module, aes_rk_select: combinational round-index-to-round-key mux, reused later by the forward cipher controller.

Test Plan:
- Functional: FIPS-197 C.1 key 000102…0f, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, controller driving the reference datapath model -> state = 00112233445566778899aabbccddeeff at done, done on edge 69.
- Sequence trace: log op_sel/round per cycle -> exactly LOAD, ARK(10), then [ISR, ISB, ARK(r), IMC w0..w3] for r=9..1, then ISR, ISB, ARK(0), DONE. round_key equals key_schedule slice r in every ARK cycle.
- Handshake: hold start=1 for 100 cycles -> single run, done stays 1; drop start -> IDLE next edge, done=0; reassert -> second identical run.
- Reset mid-run: assert RESET during round 5 IMC w2 -> next edge IDLE, busy=0, done=0, round=10. A subsequent start produces the correct plaintext.
- Start while busy: pulse start at cycle 30 -> no restart; done still on edge 69.
- AES_CTRL_KEYWAIT_EN: key_ready low for 20 cycles after start -> busy=1, state_ld=0 throughout; LOAD on the cycle after key_ready rises, done 68 cycles after that.

Source files
------------

// File: rtl/aes_ctrl_pkg.sv
// Shared types and defaults for the AES inverse-cipher controller family.
// Optional macro AES_CTRL_KEYWAIT_EN uses the ST_KWAIT encoding below.
package aes_ctrl_pkg;

  localparam int NR_DEF    = 10;
  localparam int KEY_W_DEF = 128;

  // Datapath mux select presented to the state register input.
  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_LOAD = 3'd1,
    OP_ISR  = 3'd2,
    OP_ISB  = 3'd3,
    OP_ARK  = 3'd4,
    OP_IMC  = 3'd5
  } op_e;

  // Sequencer states; ST_KWAIT is only reachable with key-wait enabled.
  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_LOAD  = 4'd1,
    ST_ARK0  = 4'd2,
    ST_ISR   = 4'd3,
    ST_ISB   = 4'd4,
    ST_ARK   = 4'd5,
    ST_IMC   = 4'd6,
    ST_DONE  = 4'd7,
    ST_KWAIT = 4'd8
  } ctrl_state_e;

  // True for states in which the datapath state register is written.
  function automatic logic state_writes(input ctrl_state_e st);
    return (st != ST_IDLE) && (st != ST_DONE) && (st != ST_KWAIT);
  endfunction

endpackage

// File: rtl/aes_rk_select.sv
// Round-index to round-key multiplexer over an expanded key schedule.
// Round r occupies bits [KEY_W*r +: KEY_W]; indices above NR yield zero.
module aes_rk_select
  import aes_ctrl_pkg::*;
#(
  parameter int NR    = NR_DEF,
  parameter int KEY_W = KEY_W_DEF
) (
  input  logic [(NR+1)*KEY_W-1:0] i_key_schedule,
  input  logic [3:0]              i_round,
  output logic [KEY_W-1:0]        o_round_key
);

  // Select the key slice addressed by the current round index.
  always_comb begin
    o_round_key = '0;
    for (int r = 0; r <= NR; r++) begin
      o_round_key = (i_round == 4'(r)) ? i_key_schedule[KEY_W*r +: KEY_W] : o_round_key;
    end
  end

endmodule

// File: rtl/aes_inv_cipher_ctrl.sv
// AES-128 inverse-cipher sequencer: steps LOAD, ARK(NR), then
// ISR/ISB/ARK/IMC x4 per round down to ARK(0), one operation per cycle.
// Control outputs are registered copies of the current state's decode,
// so each operation is presented one cycle after the FSM enters it.
// Optional macro AES_CTRL_KEYWAIT_EN adds key_ready and a KWAIT state.
module aes_inv_cipher_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int NR    = NR_DEF,
  parameter int KEY_W = KEY_W_DEF
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    start,
  input  logic [(NR+1)*KEY_W-1:0] key_schedule,
`ifdef AES_CTRL_KEYWAIT_EN
  input  logic                    key_ready,
`endif
  output logic [2:0]              op_sel,
  output logic                    state_ld,
  output logic [1:0]              imc_word,
  output logic [3:0]              round,
  output logic [KEY_W-1:0]        round_key,
  output logic                    busy,
  output logic                    done
);

  localparam logic [3:0] NR_L = 4'(NR);

  ctrl_state_e r_state;
  logic [3:0]  r_rnd;
  logic [1:0]  r_imc;
  op_e         r_op_sel;
  logic        r_state_ld;
  logic [1:0]  r_imc_word;
  logic [3:0]  r_round;
  logic        r_busy;
  logic        r_done;

  ctrl_state_e w_state_n;
  logic [3:0]  w_rnd_n;
  logic [1:0]  w_imc_n;
  op_e         w_op;
  logic        w_ld;
  logic        w_busy;
  logic        w_done;

  // Next-state, counter and output decode for the current state.
  always_comb begin
    w_state_n = r_state;
    w_rnd_n   = r_rnd;
    w_imc_n   = r_imc;
    w_op      = OP_NONE;
    w_ld      = state_writes(r_state);
    w_busy    = 1'b1;
    w_done    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_busy  = 1'b0;
        w_rnd_n = NR_L;
        w_imc_n = 2'd0;
        if (start) begin
`ifdef AES_CTRL_KEYWAIT_EN
          w_state_n = ST_KWAIT;
`else
          w_state_n = ST_LOAD;
`endif
        end else begin
          w_state_n = ST_IDLE;
        end
      end
`ifdef AES_CTRL_KEYWAIT_EN
      ST_KWAIT: begin
        w_rnd_n = NR_L;
        if (key_ready) begin
          w_state_n = ST_LOAD;
        end else begin
          w_state_n = ST_KWAIT;
        end
      end
`endif
      ST_LOAD: begin
        w_op      = OP_LOAD;
        w_state_n = ST_ARK0;
      end
      ST_ARK0: begin
        w_op      = OP_ARK;
        w_rnd_n   = NR_L - 4'd1;
        w_state_n = ST_ISR;
      end
      ST_ISR: begin
        w_op      = OP_ISR;
        w_state_n = ST_ISB;
      end
      ST_ISB: begin
        w_op      = OP_ISB;
        w_state_n = ST_ARK;
      end
      ST_ARK: begin
        w_op    = OP_ARK;
        w_imc_n = 2'd0;
        if (r_rnd == 4'd0) begin
          w_state_n = ST_DONE;
        end else begin
          w_state_n = ST_IMC;
        end
      end
      ST_IMC: begin
        w_op = OP_IMC;
        if (r_imc == 2'd3) begin
          w_imc_n   = 2'd0;
          w_rnd_n   = r_rnd - 4'd1;
          w_state_n = ST_ISR;
        end else begin
          w_imc_n   = r_imc + 2'd1;
          w_state_n = ST_IMC;
        end
      end
      ST_DONE: begin
        w_busy = 1'b0;
        if (start) begin
          w_done    = 1'b1;
          w_state_n = ST_DONE;
        end else begin
          w_done    = 1'b0;
          w_state_n = ST_IDLE;
        end
      end
      default: begin
        w_busy    = 1'b0;
        w_ld      = 1'b0;
        w_state_n = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered control outputs with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state    <= ST_IDLE;
      r_rnd      <= NR_L;
      r_imc      <= 2'd0;
      r_op_sel   <= OP_NONE;
      r_state_ld <= 1'b0;
      r_imc_word <= 2'd0;
      r_round    <= NR_L;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_rnd      <= w_rnd_n;
      r_imc      <= w_imc_n;
      r_op_sel   <= w_op;
      r_state_ld <= w_ld;
      r_imc_word <= r_imc;
      r_round    <= r_rnd;
      r_busy     <= w_busy;
      r_done     <= w_done;
    end
  end

  assign op_sel   = r_op_sel;
  assign state_ld = r_state_ld;
  assign imc_word = r_imc_word;
  assign round    = r_round;
  assign busy     = r_busy;
  assign done     = r_done;

  aes_rk_select #(
    .NR    (NR),
    .KEY_W (KEY_W)
  ) u_rk_select (
    .i_key_schedule (key_schedule),
    .i_round        (r_round),
    .o_round_key    (round_key)
  );

endmodule
